wac_control: RTL and testbench

- Command decoder between the UART receiver and the analog-control peripherals (16-bit DAC, four 8-bit digital potentiometers).
- Accepts one received byte per rising edge of a byte-valid strobe and parses short command frames.
- Loads the DAC or pot data registers, issues one-cycle load strobes to the peripheral drivers, and returns an acknowledge byte for the UART transmitter.

---
 rtl/wac_control_pkg.sv | 36 +++
 rtl/wac_control_strobe_edge_detect.sv | 22 ++
 rtl/wac_control.sv | 136 +++++++++++++
 tb/tb_wac_control.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wac_control_pkg.sv
// Shared constants and types for the wac_control command decoder.
// Holds opcode bytes, the error acknowledge code, FSM states and seg encoding.
package wac_control_pkg;

    localparam logic [7:0] CMD_DAC  = 8'h64;
    localparam logic [7:0] CMD_POT  = 8'h70;
    localparam logic [7:0] CMD_TEST = 8'h74;
    localparam logic [7:0] ACK_ERR  = 8'h3F;

    localparam logic [1:0] SEG_IDLE = 2'b00;
    localparam logic [1:0] SEG_DAC  = 2'b01;
    localparam logic [1:0] SEG_POT  = 2'b10;
    localparam logic [1:0] SEG_ERR  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StDacHi,
        StDacLo,
        StPotSel,
        StPotVal
    } state_e;

    // Debug LED code for a state; err only matters while idle.
    function automatic logic [1:0] seg_for_state(input state_e state, input logic err);
        logic [1:0] code;
        code = SEG_IDLE;
        unique case (state)
            StIdle:             code = err ? SEG_ERR : SEG_IDLE;
            StDacHi, StDacLo:   code = SEG_DAC;
            StPotSel, StPotVal: code = SEG_POT;
            default:            code = SEG_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/wac_control_strobe_edge_detect.sv
// Rising-edge detector for the UART byte-valid strobe.
// One byte_evt per rising edge of tx_send, however long it stays high.
module wac_control_strobe_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic tx_send,
    output logic byte_evt
);

    logic tx_send_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_send_q <= 1'b0;
        end else begin
            tx_send_q <= tx_send;
        end
    end

    assign byte_evt = tx_send & ~tx_send_q;

endmodule

// File: rtl/wac_control.sv
// Command decoder between the UART receiver and the DAC / digital-pot drivers.
// Parses d/p/t frames, loads peripheral registers, returns an acknowledge byte.
module wac_control
    import wac_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        tx_send,
    output logic [7:0]  data_out,
    output logic        ctrl_dac,
    output logic [15:0] dato_dac,
    output logic [1:0]  mux_dpot,
    output logic        ctrl_dpot,
    output logic [7:0]  dato_dpot,
    output logic [1:0]  seg
);

    logic byte_evt;

    state_e      state_q, state_d;
    logic [7:0]  dac_hi_q, dac_hi_d;
    logic [1:0]  chan_q, chan_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [15:0] dato_dac_q, dato_dac_d;
    logic [1:0]  mux_dpot_q, mux_dpot_d;
    logic [7:0]  dato_dpot_q, dato_dpot_d;
    logic        ctrl_dac_q, ctrl_dac_d;
    logic        ctrl_dpot_q, ctrl_dpot_d;
    logic        err_q, err_d;

    wac_control_strobe_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .tx_send  (tx_send),
        .byte_evt (byte_evt)
    );

    always_comb begin
        state_d     = state_q;
        dac_hi_d    = dac_hi_q;
        chan_d      = chan_q;
        data_out_d  = data_out_q;
        dato_dac_d  = dato_dac_q;
        mux_dpot_d  = mux_dpot_q;
        dato_dpot_d = dato_dpot_q;
        ctrl_dac_d  = 1'b0;
        ctrl_dpot_d = 1'b0;
        err_d       = err_q;

        if (byte_evt) begin
            unique case (state_q)
                StIdle: begin
                    // Only the first byte of a frame is treated as an opcode.
                    unique case (data_in)
                        CMD_DAC: begin
                            state_d = StDacHi;
                            err_d   = 1'b0;
                        end
                        CMD_POT: begin
                            state_d = StPotSel;
                            err_d   = 1'b0;
                        end
                        CMD_TEST: begin
                            data_out_d = CMD_TEST;
                            err_d      = 1'b0;
                        end
                        default: begin
                            data_out_d = ACK_ERR;
                            err_d      = 1'b1;
                        end
                    endcase
                end
                StDacHi: begin
                    dac_hi_d = data_in;
                    state_d  = StDacLo;
                end
                StDacLo: begin
                    dato_dac_d = {dac_hi_q, data_in};
                    ctrl_dac_d = 1'b1;
                    data_out_d = CMD_DAC;
                    state_d    = StIdle;
                end
                StPotSel: begin
                    chan_d  = data_in[1:0];
                    state_d = StPotVal;
                end
                StPotVal: begin
                    mux_dpot_d  = chan_q;
                    dato_dpot_d = data_in;
                    ctrl_dpot_d = 1'b1;
                    data_out_d  = CMD_POT;
                    state_d     = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dac_hi_q    <= 8'h00;
            chan_q      <= 2'b00;
            data_out_q  <= 8'h00;
            dato_dac_q  <= 16'h0000;
            mux_dpot_q  <= 2'b00;
            dato_dpot_q <= 8'h00;
            ctrl_dac_q  <= 1'b0;
            ctrl_dpot_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dac_hi_q    <= dac_hi_d;
            chan_q      <= chan_d;
            data_out_q  <= data_out_d;
            dato_dac_q  <= dato_dac_d;
            mux_dpot_q  <= mux_dpot_d;
            dato_dpot_q <= dato_dpot_d;
            ctrl_dac_q  <= ctrl_dac_d;
            ctrl_dpot_q <= ctrl_dpot_d;
            err_q       <= err_d;
        end
    end

    assign data_out  = data_out_q;
    assign dato_dac  = dato_dac_q;
    assign mux_dpot  = mux_dpot_q;
    assign dato_dpot = dato_dpot_q;
    assign ctrl_dac  = ctrl_dac_q;
    assign ctrl_dpot = ctrl_dpot_q;
    assign seg       = seg_for_state(state_q, err_q);

endmodule

// File: tb/tb_wac_control.sv
// Self-checking bench for wac_control: directed frames plus randomized byte
// streams compared against a frame-level reference model.
module tb_wac_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        tx_send;
    logic [7:0]  data_out;
    logic        ctrl_dac;
    logic [15:0] dato_dac;
    logic [1:0]  mux_dpot;
    logic        ctrl_dpot;
    logic [7:0]  dato_dpot;
    logic [1:0]  seg;

    wac_control dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .tx_send   (tx_send),
        .data_out  (data_out),
        .ctrl_dac  (ctrl_dac),
        .dato_dac  (dato_dac),
        .mux_dpot  (mux_dpot),
        .ctrl_dpot (ctrl_dpot),
        .dato_dpot (dato_dpot),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Strobe monitor, sampled on the falling edge.
    int          dac_pulses  = 0;
    int          dpot_pulses = 0;
    int          wide_pulses = 0;
    int          overlaps    = 0;
    logic        prev_dac    = 1'b0;
    logic        prev_dpot   = 1'b0;
    logic [15:0] dac_at_pulse  = 16'h0;
    logic [1:0]  mux_at_pulse  = 2'h0;
    logic [7:0]  dpot_at_pulse = 8'h0;

    always @(negedge clk) begin
        if (ctrl_dac === 1'b1) begin
            dac_pulses++;
            dac_at_pulse = dato_dac;
            if (prev_dac === 1'b1) wide_pulses++;
        end
        if (ctrl_dpot === 1'b1) begin
            dpot_pulses++;
            mux_at_pulse  = mux_dpot;
            dpot_at_pulse = dato_dpot;
            if (prev_dpot === 1'b1) wide_pulses++;
        end
        if (ctrl_dac === 1'b1 && ctrl_dpot === 1'b1) overlaps++;
        prev_dac  = ctrl_dac;
        prev_dpot = ctrl_dpot;
    end

    // Reference model: collects frames as byte lists and applies them whole.
    logic [7:0]  frame[$];
    logic [7:0]  m_data;
    logic [15:0] m_dac;
    logic [1:0]  m_mux;
    logic [7:0]  m_dpot;
    bit          m_err;
    int          m_dac_pulses  = 0;
    int          m_dpot_pulses = 0;

    function automatic logic [1:0] m_seg();
        if (frame.size() == 0) return m_err ? 2'd3 : 2'd0;
        return (frame[0] == 8'h64) ? 2'd1 : 2'd2;
    endfunction

    task automatic model_reset();
        frame.delete();
        m_data = 8'h00;
        m_dac  = 16'h0000;
        m_mux  = 2'd0;
        m_dpot = 8'h00;
        m_err  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (frame.size() == 0) begin
            if (b == 8'h64 || b == 8'h70) begin
                frame.push_back(b);
                m_err = 1'b0;
            end else if (b == 8'h74) begin
                m_data = 8'h74;
                m_err  = 1'b0;
            end else begin
                m_data = 8'h3F;
                m_err  = 1'b1;
            end
        end else begin
            frame.push_back(b);
            if (frame.size() == 3) begin
                if (frame[0] == 8'h64) begin
                    m_dac = {frame[1], frame[2]};
                    m_dac_pulses++;
                end else begin
                    m_mux  = frame[1][1:0];
                    m_dpot = frame[2];
                    m_dpot_pulses++;
                end
                m_data = frame[0];
                frame.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        @(negedge clk);
        data_in = b;
        tx_send = 1'b1;
        repeat (hi) @(negedge clk);
        tx_send = 1'b0;
        data_in = 8'($urandom);
        model_byte(b);
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        tx_send = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h expected 00", data_out);
        else passed++;
        total++;
        if (dato_dac !== 16'h0000) $display("FAIL reset_dato_dac: got %h expected 0000", dato_dac);
        else passed++;
        total++;
        if ({mux_dpot, dato_dpot} !== 10'h000)
            $display("FAIL reset_pot: got %h/%h expected 0/00", mux_dpot, dato_dpot);
        else passed++;
        total++;
        if ({ctrl_dac, ctrl_dpot, seg} !== 4'h0)
            $display("FAIL reset_strobes_seg: got %b%b/%b expected 00/00", ctrl_dac, ctrl_dpot, seg);
        else passed++;
    endtask

    task automatic test_echo();
        int d0;
        int p0;
        d0 = dac_pulses;
        p0 = dpot_pulses;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h74, 2, 77);
            total++;
            if (data_out !== 8'h74) $display("FAIL echo_data_out[%0d]: got %h expected 74", i, data_out);
            else passed++;
            total++;
            if (seg !== 2'b00) $display("FAIL echo_seg[%0d]: got %b expected 00", i, seg);
            else passed++;
        end
        total++;
        if ((dac_pulses - d0) + (dpot_pulses - p0) !== 0)
            $display("FAIL echo_no_strobes: got %0d expected 0", (dac_pulses - d0) + (dpot_pulses - p0));
        else passed++;
    endtask

    task automatic test_dac();
        int d0;
        d0 = dac_pulses;
        send_byte(8'h64, 3, 3);
        total++;
        if (seg !== 2'b01) $display("FAIL dac_seg_mid: got %b expected 01", seg);
        else passed++;
        send_byte(8'h12, 4, 3);
        total++;
        if (seg !== 2'b01 || dato_dac !== 16'h0000)
            $display("FAIL dac_shadow: got seg %b dac %h expected 01 0000", seg, dato_dac);
        else passed++;
        send_byte(8'h34, 2, 4);
        total++;
        if (dato_dac !== 16'h1234) $display("FAIL dac_value: got %h expected 1234", dato_dac);
        else passed++;
        total++;
        if (dac_pulses - d0 !== 1 || dac_at_pulse !== 16'h1234)
            $display("FAIL dac_strobe: got %0d pulses at %h expected 1 at 1234", dac_pulses - d0, dac_at_pulse);
        else passed++;
        total++;
        if (data_out !== 8'h64 || seg !== 2'b00)
            $display("FAIL dac_ack: got %h seg %b expected 64 seg 00", data_out, seg);
        else passed++;
    endtask

    task automatic test_pot();
        int p0;
        p0 = dpot_pulses;
        send_byte(8'h70, 2, 3);
        total++;
        if (seg !== 2'b10) $display("FAIL pot_seg_mid: got %b expected 10", seg);
        else passed++;
        send_byte(8'h06, 2, 3);
        send_byte(8'hA5, 5, 3);
        total++;
        if (mux_dpot !== 2'd2 || dato_dpot !== 8'hA5)
            $display("FAIL pot_value: got %0d/%h expected 2/a5", mux_dpot, dato_dpot);
        else passed++;
        total++;
        if (dpot_pulses - p0 !== 1 || mux_at_pulse !== 2'd2 || dpot_at_pulse !== 8'hA5)
            $display("FAIL pot_strobe: got %0d pulses at %0d/%h expected 1 at 2/a5",
                     dpot_pulses - p0, mux_at_pulse, dpot_at_pulse);
        else passed++;
        total++;
        if (data_out !== 8'h70) $display("FAIL pot_ack: got %h expected 70", data_out);
        else passed++;
    endtask

    task automatic test_unknown();
        send_byte(8'h55, 2, 3);
        total++;
        if (data_out !== 8'h3F || seg !== 2'b11)
            $display("FAIL unknown_ack: got %h seg %b expected 3f seg 11", data_out, seg);
        else passed++;
        send_byte(8'h74, 2, 3);
        total++;
        if (data_out !== 8'h74 || seg !== 2'b00)
            $display("FAIL unknown_clear: got %h seg %b expected 74 seg 00", data_out, seg);
        else passed++;
    endtask

    task automatic test_arg_not_decoded();
        send_byte(8'h64, 2, 3);
        send_byte(8'h74, 2, 3);
        send_byte(8'h74, 2, 3);
        total++;
        if (dato_dac !== 16'h7474 || data_out !== 8'h64)
            $display("FAIL arg_data: got %h ack %h expected 7474 ack 64", dato_dac, data_out);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        int d0;
        send_byte(8'h64, 2, 3);
        send_byte(8'hAB, 2, 3);
        d0 = dac_pulses;
        pulse_reset();
        send_byte(8'h74, 2, 3);
        total++;
        if (dato_dac !== 16'h0000 || dac_pulses - d0 !== 0)
            $display("FAIL midrst_dac: got %h pulses %0d expected 0000 pulses 0", dato_dac, dac_pulses - d0);
        else passed++;
        total++;
        if (data_out !== 8'h74 || seg !== 2'b00)
            $display("FAIL midrst_idle: got %h seg %b expected 74 seg 00", data_out, seg);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'h64;
            else if (r < 4) b = 8'h70;
            else if (r == 4) b = 8'h74;
            else b = 8'($urandom);
            send_byte(b, $urandom_range(1, 4), $urandom_range(2, 5));
            total++;
            if ({data_out, dato_dac, mux_dpot, dato_dpot, seg} !== {m_data, m_dac, m_mux, m_dpot, m_seg()})
                $display("FAIL random[%0d] byte %h: got %h/%h/%0d/%h/%b expected %h/%h/%0d/%h/%b", i, b,
                         data_out, dato_dac, mux_dpot, dato_dpot, seg,
                         m_data, m_dac, m_mux, m_dpot, m_seg());
            else passed++;
        end
        total++;
        if (dac_pulses !== m_dac_pulses || dpot_pulses !== m_dpot_pulses)
            $display("FAIL pulse_counts: got %0d/%0d expected %0d/%0d",
                     dac_pulses, dpot_pulses, m_dac_pulses, m_dpot_pulses);
        else passed++;
        total++;
        if (wide_pulses !== 0 || overlaps !== 0)
            $display("FAIL pulse_shape: got wide %0d overlap %0d expected 0/0", wide_pulses, overlaps);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_echo();
        test_dac();
        test_pot();
        test_unknown();
        test_arg_not_decoded();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
